i2c_txn_controller: RTL and testbench
=====================================

I2C_TXN_CONTROLLER -- requirements
Module: i2c_txn_controller

Interface
REQ-001 SHALL have parameter DEVICE_ADDR, default 7'h2A, meaning the 7-bit I2C peripheral address matched after START.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the synchronizer depth applied to sck and sda.
REQ-003 clk  input  1  system clock; the block has one clock, and all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sck  input  1  raw I2C clock from the pad.
REQ-006 read_channel  input  1  raw SDA value from the pad.
REQ-007 direction  output  8  pad drive mask: 8'hFF when driving SDA, 8'h00 when released.
REQ-008 write_channel  output  1  SDA drive value; meaningful only when direction==8'hFF.
REQ-009 rx_data  output  8  last byte received from the master, MSB first.
REQ-010 rx_valid  output  1  one-clk pulse when rx_data is updated.
REQ-011 tx_data  input  8  byte returned on a master read; sampled on tx_load.
REQ-012 tx_load  output  1  one-clk pulse when tx_data is captured into the shift register.
REQ-013 start_seen / stop_seen  output  1 each  one-clk pulses on detected START (including repeated START) and on detected STOP.
REQ-014 busy  output  1  high from START until STOP.

Function
REQ-015 sck and read_channel SHALL each pass through SYNC_STAGES flops; edge detection SHALL compare the synced value with a one-cycle-delayed copy, giving a pad-to-event latency of SYNC_STAGES+1 clks.
REQ-016 START detection: synced SDA falls while synced SCK is high and was high the previous cycle.
REQ-017 STOP detection: synced SDA rises under the same SCK condition as REQ-016.
REQ-018 Data bits SHALL be sampled on the synced SCK rising edge; SDA drive changes SHALL occur only on the synced SCK falling edge.
REQ-019 The FSM SHALL have the states IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK and IGNORE.
REQ-020 START from any state: enter ADDR, clear the 3-bit bit counter, set busy, pulse start_seen; START takes priority over a same-cycle SCK edge.
REQ-021 STOP from any state: enter IDLE, release SDA, clear busy, pulse stop_seen.
REQ-022 ADDR: shift in 8 bits (7 address bits plus R/W); after the 8th rising edge, a matching address goes to ADDR_ACK and a mismatch goes to IGNORE.
REQ-023 ADDR_ACK:
  - on the next falling edge, drive 0 (direction=FF, write_channel=0);
  - on the following falling edge, release the bus;
  - if R/W=0, go to RX_BYTE;
  - if R/W=1, pulse tx_load, load tx_data, drive its MSB and go to TX_BYTE.
REQ-024 RX_BYTE: after 8 bits, update rx_data, pulse rx_valid in the same clk as the 8th rising edge, then follow the ACK drive/release timing of REQ-023 (RX_ACK) and return to RX_BYTE.
REQ-025 TX_BYTE: shift out MSB first on falling edges; after the 8th bit, release SDA and go to TX_ACK.
REQ-026 TX_ACK: sample the master's bit on the rising edge.
  - ACK (0): pulse tx_load, reload tx_data, drive its MSB on the next falling edge, return to TX_BYTE.
  - NACK (1): go to IGNORE.
REQ-027 IGNORE: never drive SDA; leave only on START or STOP.
REQ-028 The bit counter SHALL be 3 bits and wrap 7->0 at each byte boundary; no overflow state exists.
REQ-029 The block SHALL never drive SDA high (write_channel=1 with direction=FF); when not driving 0, direction SHALL be 8'h00.
REQ-030 Pulse outputs SHALL be exactly one clk wide and never asserted while reset is high.

Reset
REQ-031 Asserting reset, including mid-transfer, SHALL immediately force:
  - state IDLE;
  - direction=8'h00, write_channel=0;
  - rx_data=8'h00, rx_valid=0, tx_load=0;
  - start_seen=0, stop_seen=0, busy=0;
  - synchronizers, counter and shift registers to 0.
REQ-032 After reset release, the block SHALL ignore bus activity until the next START.

Verification
REQ-033 Write: START, address 0x54 (0x2A, W), data 0xA5, STOP -> ACK driven on both 9th bits; rx_data=0xA5 with one rx_valid pulse; start_seen and stop_seen pulse once each.
REQ-034 Read: START, address 0x55, tx_data=0x3C, master ACK then NACK, tx_data=0xC3 on the second byte -> SDA carries 0x3C then 0xC3; two tx_load pulses; bus released after the NACK.
REQ-035 Address mismatch 0x20 followed by data 0xFF -> direction stays 8'h00 throughout; no rx_valid; busy stays high until STOP.
REQ-036 Repeated START after a write byte, then address 0x55 -> ADDR re-entered, second start_seen pulse, read proceeds with busy held high.
REQ-037 Reset asserted while the block drives an ACK -> direction=8'h00 in the same cycle; a following data byte without START produces no response.
REQ-038 STOP injected mid-byte (after 4 bits) -> IDLE, SDA released, no rx_valid.

Source files
------------

// File: rtl/i2c_txn_controller.sv
// I2C peripheral transaction controller: synchronises the pads, detects START/STOP,
// matches a 7-bit address and moves bytes in or out with open-drain ACK handling.
module i2c_txn_controller #(
  parameter logic [6:0] DEVICE_ADDR = 7'h2A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       read_channel,
  input  logic [7:0] tx_data,
  output logic [7:0] direction,
  output logic       write_channel,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_load,
  output logic       start_seen,
  output logic       stop_seen,
  output logic       busy,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, sda_sync_q;
  logic       scl_prev_q, sda_prev_q;
  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [6:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       drive_q, drive_d;
  logic       acked_q, acked_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_load_q, tx_load_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;
  logic       busy_q, busy_d;

  logic scl, sda, scl_rise, scl_fall, start_det, stop_det;

  assign scl       = sck_sync_q[SYNC_STAGES-1];
  assign sda       = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl & ~scl_prev_q;
  assign scl_fall  = ~scl & scl_prev_q;
  assign start_det = scl & scl_prev_q & sda_prev_q & ~sda;
  assign stop_det  = scl & scl_prev_q & ~sda_prev_q & sda;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    drive_d    = drive_q;
    acked_d    = acked_q;
    rx_data_d  = rx_data_q;
    busy_d     = busy_q;
    rx_valid_d = 1'b0;
    tx_load_d  = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    if (start_det) begin
      state_d = ADDR;
      cnt_d   = 3'd0;
      drive_d = 1'b0;
      acked_d = 1'b0;
      busy_d  = 1'b1;
      start_d = 1'b1;
    end else if (stop_det) begin
      state_d = IDLE;
      drive_d = 1'b0;
      busy_d  = 1'b0;
      stop_d  = 1'b1;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_d = {shift_q[5:0], sda};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            rw_d    = sda;
            state_d = (shift_q == DEVICE_ADDR) ? ADDR_ACK : IGNORE;
          end
        end
        // First falling edge pulls SDA low, the next one releases and moves on.
        ADDR_ACK, RX_ACK: if (scl_fall) begin
          if (!drive_q) begin
            drive_d = 1'b1;
          end else if (state_q == RX_ACK || !rw_q) begin
            drive_d = 1'b0;
            state_d = RX_BYTE;
          end else begin
            tx_load_d = 1'b1;
            shift_d   = tx_data[6:0];
            drive_d   = ~tx_data[7];
            cnt_d     = 3'd0;
            state_d   = TX_BYTE;
          end
        end
        RX_BYTE: if (scl_rise) begin
          shift_d = {shift_q[5:0], sda};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            rx_data_d  = {shift_q, sda};
            rx_valid_d = 1'b1;
            state_d    = RX_ACK;
          end
        end
        // The counter wraps to 0 on the 8th rising edge, so a falling edge
        // seen with cnt_q==0 is the one that ends the byte.
        TX_BYTE: if (scl_rise) begin
          cnt_d = cnt_q + 3'd1;
        end else if (scl_fall) begin
          if (cnt_q == 3'd0) begin
            drive_d = 1'b0;
            acked_d = 1'b0;
            state_d = TX_ACK;
          end else begin
            drive_d = ~shift_q[6];
            shift_d = {shift_q[5:0], 1'b0};
          end
        end
        TX_ACK: if (scl_rise) begin
          if (sda) state_d = IGNORE;
          else     acked_d = 1'b1;
        end else if (scl_fall && acked_q) begin
          tx_load_d = 1'b1;
          shift_d   = tx_data[6:0];
          drive_d   = ~tx_data[7];
          cnt_d     = 3'd0;
          acked_d   = 1'b0;
          state_d   = TX_BYTE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync_q <= '0;
      sda_sync_q <= '0;
      scl_prev_q <= 1'b0;
      sda_prev_q <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      shift_q    <= 7'd0;
      rw_q       <= 1'b0;
      drive_q    <= 1'b0;
      acked_q    <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      tx_load_q  <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sck_sync_q <= (sck_sync_q << 1) | SYNC_STAGES'(sck);
      sda_sync_q <= (sda_sync_q << 1) | SYNC_STAGES'(read_channel);
      scl_prev_q <= scl;
      sda_prev_q <= sda;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rw_q       <= rw_d;
      drive_q    <= drive_d;
      acked_q    <= acked_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_load_q  <= tx_load_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      busy_q     <= busy_d;
    end
  end

  // Open-drain: only ever pull low, so the drive value is a constant zero.
  assign direction     = {8{drive_q}};
  assign write_channel = 1'b0;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;
  assign tx_load       = tx_load_q;
  assign start_seen    = start_q;
  assign stop_seen     = stop_q;
  assign busy          = busy_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_i2c_txn_controller.sv
// Bench for i2c_txn_controller: bit-banged I2C master over an open-drain line model,
// a table of write transactions plus hand-written read / restart / reset / stop cases.
module tb_i2c_txn_controller;

  localparam int H = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       sck;
  logic       sda_m;
  logic       read_channel;
  logic [7:0] tx_data;
  logic [7:0] direction;
  logic       write_channel;
  logic [7:0] rx_data;
  logic       rx_valid, tx_load, start_seen, stop_seen, busy;
  logic [2:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int n_start = 0, n_stop = 0, n_rxv = 0, n_txl = 0;
  int bad_pulse = 0, bad_drive = 0;
  logic dir_seen = 1'b0;
  logic [3:0] prev_pulses = '0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  assign read_channel = sda_m & ~(direction == 8'hFF && write_channel == 1'b0);

  i2c_txn_controller #(.DEVICE_ADDR(7'h2A), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .sck(sck), .read_channel(read_channel),
    .tx_data(tx_data), .direction(direction), .write_channel(write_channel),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_load(tx_load),
    .start_seen(start_seen), .stop_seen(stop_seen), .busy(busy),
    .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor and scoreboard: pulse counters, drive legality and rx byte checks.
  always @(negedge clk) begin
    logic [3:0] p;
    p = {rx_valid, tx_load, start_seen, stop_seen};
    if ((p & prev_pulses) != 0) bad_pulse++;
    if (reset && p != 0) bad_pulse++;
    prev_pulses = p;
    if (direction != 8'h00 && direction != 8'hFF) bad_drive++;
    if (direction == 8'hFF && write_channel) bad_drive++;
    if (direction != 8'h00) dir_seen = 1'b1;
    if (start_seen) n_start++;
    if (stop_seen)  n_stop++;
    if (tx_load)    n_txl++;
    if (rx_valid) begin
      n_rxv++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rx_unexpected actual=%0h expected=none", rx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rx_data !== e) begin
          errors++;
          $display("FAIL rx_data actual=%0h expected=%0h", rx_data, e);
        end
      end
    end
  end

  task automatic wait_h(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_h(H);
    sck = 1'b1;   wait_h(H);
    sda_m = 1'b0; wait_h(H);
    sck = 1'b0;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_h(H);
    sck = 1'b1;   wait_h(H);
    sda_m = 1'b1; wait_h(H);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; wait_h(H);
    sck = 1'b1; wait_h(H);
    sck = 1'b0;
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; wait_h(H);
    sck = 1'b1; wait_h(H / 2);
    b = read_channel; wait_h(H / 2);
    sck = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
  endtask

  task automatic read_byte(output logic [7:0] v);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       match;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic b;
    logic [7:0] v;
    int s0, p0, r0, t0;
    bit found;

    vecs[0] = '{8'h54, 8'hA5, 1'b1};
    vecs[1] = '{8'h54, 8'h00, 1'b1};
    vecs[2] = '{8'h54, 8'hFF, 1'b1};
    vecs[3] = '{8'h20, 8'hFF, 1'b0};
    vecs[4] = '{8'h56, 8'h3C, 1'b0};
    vecs[5] = '{8'h54, 8'h5A, 1'b1};

    // Clock / reset.
    reset = 1'b1; sck = 1'b1; sda_m = 1'b1; tx_data = 8'h00;
    wait_h(5);
    check("reset_direction", direction, 8'h00);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_busy", busy, 1'b0);
    check("reset_state", dbg_state, 3'd0);
    reset = 1'b0;
    wait_h(10);
    check("post_reset_busy", busy, 1'b0);
    check("post_reset_pulses", {rx_valid, tx_load, start_seen, stop_seen}, 4'h0);

    // Table-driven write transactions.
    foreach (vecs[k]) begin
      s0 = n_start; p0 = n_stop; r0 = n_rxv;
      dir_seen = 1'b0;
      i2c_start();
      write_byte(vecs[k].addr);
      read_bit(b);
      check($sformatf("v%0d_addr_ack", k), b, !vecs[k].match);
      if (vecs[k].match) exp_q.push_back(vecs[k].data);
      write_byte(vecs[k].data);
      read_bit(b);
      check($sformatf("v%0d_data_ack", k), b, !vecs[k].match);
      check($sformatf("v%0d_busy", k), busy, 1'b1);
      i2c_stop();
      check($sformatf("v%0d_busy_after_stop", k), busy, 1'b0);
      check($sformatf("v%0d_start_cnt", k), n_start - s0, 1);
      check($sformatf("v%0d_stop_cnt", k), n_stop - p0, 1);
      check($sformatf("v%0d_rxv_cnt", k), n_rxv - r0, vecs[k].match ? 1 : 0);
      check($sformatf("v%0d_dir_seen", k), dir_seen, vecs[k].match);
    end

    // Read: two bytes, master ACK then NACK.
    t0 = n_txl;
    tx_data = 8'h3C;
    i2c_start();
    write_byte(8'h55);
    read_bit(b);
    check("rd_addr_ack", b, 1'b0);
    read_byte(v);
    check("rd_byte0", v, 8'h3C);
    tx_data = 8'hC3;
    write_bit(1'b0);
    read_byte(v);
    check("rd_byte1", v, 8'hC3);
    write_bit(1'b1);
    wait_h(H);
    check("rd_released_after_nack", direction, 8'h00);
    check("rd_tx_load_cnt", n_txl - t0, 2);
    i2c_stop();

    // Repeated START from a write into a read.
    s0 = n_start; p0 = n_stop;
    tx_data = 8'h5A;
    i2c_start();
    write_byte(8'h54);
    read_bit(b);
    check("rs_addr_ack", b, 1'b0);
    exp_q.push_back(8'h11);
    write_byte(8'h11);
    read_bit(b);
    check("rs_data_ack", b, 1'b0);
    i2c_start();
    check("rs_state_addr", dbg_state, 3'd1);
    check("rs_busy", busy, 1'b1);
    write_byte(8'h55);
    read_bit(b);
    check("rs_read_ack", b, 1'b0);
    read_byte(v);
    check("rs_read_byte", v, 8'h5A);
    write_bit(1'b1);
    check("rs_busy_held", busy, 1'b1);
    check("rs_start_cnt", n_start - s0, 2);
    check("rs_no_stop", n_stop - p0, 0);
    i2c_stop();
    check("rs_stop_cnt", n_stop - p0, 1);

    // Reset while the address ACK is being driven.
    i2c_start();
    write_byte(8'h54);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (direction == 8'hFF) found = 1'b1;
    end
    check("rst_ack_driven", found, 1'b1);
    reset = 1'b1;
    #1;
    check("rst_direction_now", direction, 8'h00);
    check("rst_busy_now", busy, 1'b0);
    wait_h(3);
    reset = 1'b0;
    wait_h(4);
    dir_seen = 1'b0; r0 = n_rxv; s0 = n_start;
    write_byte(8'hA5);
    read_bit(b);
    check("rst_no_ack", b, 1'b1);
    check("rst_no_drive", dir_seen, 1'b0);
    check("rst_no_rxv", n_rxv - r0, 0);
    check("rst_no_start", n_start - s0, 0);
    i2c_stop();

    // STOP injected after four data bits.
    i2c_start();
    write_byte(8'h54);
    read_bit(b);
    check("ms_addr_ack", b, 1'b0);
    r0 = n_rxv; p0 = n_stop;
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    i2c_stop();
    check("ms_state_idle", dbg_state, 3'd0);
    check("ms_direction", direction, 8'h00);
    check("ms_busy", busy, 1'b0);
    check("ms_no_rxv", n_rxv - r0, 0);
    check("ms_stop_cnt", n_stop - p0, 1);

    wait_h(10);
    check("exp_q_empty", exp_q.size(), 0);
    check("pulse_width_and_reset", bad_pulse, 0);
    check("drive_legality", bad_drive, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
